magic_sched: RTL

MAGIC_SCHED -- requirements
Module: magic_sched

---
 rtl/magic_pkg.sv | 22 ++
 rtl/magic_rr_arb.sv | 21 ++
 rtl/magic_sched.sv | 99 +++++++++
 3 files changed

// File: rtl/magic_pkg.sv
// magic_pkg: constants and the state type shared by the digit-classifier scheduler.
package magic_pkg;

    localparam int FRAME_W = 900;
    localparam int DIGIT_W = 4;
    localparam int CNT_W   = 11;

    localparam logic [DIGIT_W-1:0] DIGIT_ERR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

    // Turn the 1-bit owner index into the per-requester completion pulse.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/magic_rr_arb.sv
// magic_rr_arb: combinational 2-way round-robin arbiter; the pointer register is owned by the caller.
module magic_rr_arb
    import magic_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // A lone request always wins; on contention the pointer names the preferred requester.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/magic_sched.sv
// magic_sched: shares one digit classifier between two requesters, latching the granted frame,
// pulsing the classifier start, and returning the digit (or a timeout error) to the owner.
module magic_sched
    import magic_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [1:0]         i_req,
    input  logic [FRAME_W-1:0] i_frame0,
    input  logic [FRAME_W-1:0] i_frame1,
    output logic [1:0]         o_done,
    output logic [DIGIT_W-1:0] o_digit,
    output logic               o_err,
    output logic               o_busy,
    output logic               o_cls_start_n,
    output logic [FRAME_W-1:0] o_cls_frame,
    input  logic [DIGIT_W-1:0] i_cls_digit,
    input  logic               i_cls_valid
);

    // The counter holds the number of cycles elapsed since START, so the
    // last permitted WAIT cycle is the one where it equals TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    sched_state_t     state;
    logic             owner;
    logic             ptr;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       grant;

    magic_rr_arb u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Scheduler FSM; every output is registered and reflects the state being entered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            owner         <= 1'b0;
            ptr           <= 1'b0;
            cnt           <= '0;
            o_done        <= 2'b00;
            o_digit       <= '0;
            o_err         <= 1'b0;
            o_busy        <= 1'b0;
            o_cls_start_n <= 1'b1;
            o_cls_frame   <= '0;
        end else begin
            o_done        <= 2'b00;
            o_digit       <= '0;
            o_err         <= 1'b0;
            o_cls_start_n <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (i_req != 2'b00) begin
                        owner         <= grant[1];
                        o_cls_frame   <= grant[1] ? i_frame1 : i_frame0;
                        cnt           <= '0;
                        o_cls_start_n <= 1'b0;
                        o_busy        <= 1'b1;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    cnt   <= cnt + CNT_W'(1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (i_cls_valid) begin
                        o_done  <= owner_onehot(owner);
                        o_digit <= i_cls_digit;
                        o_err   <= 1'b0;
                        state   <= ST_DONE;
                    end else if (cnt == CNT_LAST) begin
                        o_done  <= owner_onehot(owner);
                        o_digit <= DIGIT_ERR;
                        o_err   <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr    <= ~owner;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
